// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared op codes, flag indices and field widths for the fpu pipe
package fpu_pkg;

  typedef enum logic [0:0] {
    FPU_ADD = 1'b0,
    FPU_SUB = 1'b1
  } fpu_op_e;

  localparam int FLAG_SIGN = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_INF  = 2;
  localparam int FLAG_NAN  = 3;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  function automatic logic [3:0] fpu_flags(input logic [31:0] v);
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    e = v[MANT_W +: EXP_W];
    m = v[MANT_W-1:0];
    fpu_flags            = '0;
    fpu_flags[FLAG_NAN]  = (e == '1) && (m != '0);
    fpu_flags[FLAG_INF]  = (e == '1) && (m == '0);
    fpu_flags[FLAG_ZERO] = (e == '0) && (m == '0);
    fpu_flags[FLAG_SIGN] = v[31];
  endfunction

endpackage

// File: rtl/fpu_32bit.sv
// rtl/fpu_32bit.sv - combinational single-precision add/sub core
// Rounds toward zero; denormal inputs and results are flushed to zero.
module fpu_32bit
  import fpu_pkg::*;
#(
  parameter int NUM_OP = 1
) (
  input  logic [NUM_OP-1:0] i_op,
  input  logic [31:0]       i_a,
  input  logic [31:0]       i_b,
  output logic [31:0]       o_result
);

  logic [31:0]       b_eff, opx, opy;
  logic [7:0]        dexp;
  logic [23:0]       mx, my, my_al, norm;
  logic [24:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] er;
  logic              a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    b_eff = {i_b[31] ^ (i_op == NUM_OP'(FPU_SUB)), i_b[30:0]};
    a_nan = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
    b_nan = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
    a_inf = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
    b_inf = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);
    // opx always carries the larger magnitude, so the result takes its sign
    if (i_b[30:0] > i_a[30:0]) begin
      opx = b_eff;
      opy = i_a;
    end else begin
      opx = i_a;
      opy = b_eff;
    end
    mx    = (opx[30:23] == 8'd0) ? 24'd0 : {1'b1, opx[22:0]};
    my    = (opy[30:23] == 8'd0) ? 24'd0 : {1'b1, opy[22:0]};
    dexp  = opx[30:23] - opy[30:23];
    my_al = (dexp > 8'd23) ? 24'd0 : (my >> dexp);
    sum   = (opx[31] == opy[31]) ? ({1'b0, mx} + {1'b0, my_al})
                                 : ({1'b0, mx} - {1'b0, my_al});
    lz = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (sum[i]) lz = 5'(23 - i);
    end
    if (sum[24]) begin
      norm = sum[24:1];
      er   = $signed({2'b00, opx[30:23]}) + 10'sd1;
    end else begin
      norm = sum[23:0] << lz;
      er   = $signed({2'b00, opx[30:23]}) - $signed({5'b00000, lz});
    end
    o_result = {opx[31], er[7:0], norm[22:0]};
    if (a_nan || b_nan || (a_inf && b_inf && (i_a[31] != b_eff[31]))) o_result = 32'h7FC0_0000;
    else if (a_inf)          o_result = i_a;
    else if (b_inf)          o_result = b_eff;
    else if (!norm[23])      o_result = 32'd0;
    else if (er >= 10'sd255) o_result = {opx[31], 8'hFF, 23'd0};
    else if (er <= 10'sd0)   o_result = {opx[31], 31'd0};
  end

endmodule

// File: rtl/fpu_pipe_stage.sv
// rtl/fpu_pipe_stage.sv - one elastic valid/ready register slice with flush
module fpu_pipe_stage #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    o_ready = !valid_q || i_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (o_ready) begin
      valid_d = i_valid;
      if (i_valid) data_d = i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/fpu_pipe_unit.sv
// rtl/fpu_pipe_unit.sv - elastic FP add/sub pipeline: operand stage, core, result stages
module fpu_pipe_unit
  import fpu_pkg::*;
#(
  parameter int NUM_OP      = 1,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_valid,
  input  logic [NUM_OP-1:0]                i_alu_op,
  input  logic [31:0]                      i_data_a,
  input  logic [31:0]                      i_data_b,
  input  logic [TAG_W-1:0]                 i_tag,
  input  logic                             i_flush,
  output logic                             o_ready,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [31:0]                      o_result,
  output logic [TAG_W-1:0]                 o_tag,
  output logic [3:0]                       o_flags,
  output logic [$clog2(PIPE_STAGES+1)-1:0] o_inflight
);

  localparam int W0 = NUM_OP + 64 + TAG_W;
  localparam int W1 = 36 + TAG_W;
  localparam int IW = $clog2(PIPE_STAGES + 1);

  logic [PIPE_STAGES-1:0] vld, up_rdy, dn_rdy;
  logic [W0-1:0]          s0_data;
  logic [NUM_OP-1:0]      s0_op;
  logic [31:0]            s0_a, s0_b, core_result;
  logic [TAG_W-1:0]       s0_tag;
  logic [W1-1:0]          stage1_in;
  logic [W1-1:0]          pay    [1:PIPE_STAGES-1];
  logic [W1-1:0]          pay_in [1:PIPE_STAGES-1];
  logic [IW-1:0]          inflight;

  assign dn_rdy[PIPE_STAGES-1] = i_ready;
  for (genvar k = 0; k < PIPE_STAGES - 1; k++) begin : g_rdy
    assign dn_rdy[k] = up_rdy[k+1];
  end

  fpu_pipe_stage #(.W(W0)) u_stage0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (up_rdy[0]),
    .i_data  ({i_alu_op, i_data_a, i_data_b, i_tag}),
    .o_valid (vld[0]),
    .i_ready (dn_rdy[0]),
    .o_data  (s0_data)
  );

  assign {s0_op, s0_a, s0_b, s0_tag} = s0_data;

  fpu_32bit #(.NUM_OP(NUM_OP)) u_core (
    .i_op     (s0_op),
    .i_a      (s0_a),
    .i_b      (s0_b),
    .o_result (core_result)
  );

  assign stage1_in = {core_result, fpu_flags(core_result), s0_tag};

  for (genvar k = 1; k < PIPE_STAGES; k++) begin : g_stage
    if (k == 1) begin : g_first
      assign pay_in[k] = stage1_in;
    end else begin : g_next
      assign pay_in[k] = pay[k-1];
    end
    fpu_pipe_stage #(.W(W1)) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_flush),
      .i_valid (vld[k-1]),
      .o_ready (up_rdy[k]),
      .i_data  (pay_in[k]),
      .o_valid (vld[k]),
      .i_ready (dn_rdy[k]),
      .o_data  (pay[k])
    );
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < PIPE_STAGES; k++) inflight = inflight + IW'(vld[k]);
  end

  // flush wins over accept, so the requester sees a refusal that cycle
  assign o_ready    = up_rdy[0] && !i_flush;
  assign o_valid    = vld[PIPE_STAGES-1];
  assign {o_result, o_flags, o_tag} = pay[PIPE_STAGES-1];
  assign o_inflight = inflight;

endmodule

// File: tb/tb_fpu_pipe_unit.sv
// tb/tb_fpu_pipe_unit.sv - self-checking bench for fpu_pipe_unit
module tb_fpu_pipe_unit;

  localparam int P  = 2;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [0:0]    in_op = 1'b0;
  logic [31:0]   a = '0, b = '0;
  logic [TW-1:0] tag = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b1;
  logic          o_ready, o_valid;
  logic [31:0]   res;
  logic [TW-1:0] otag;
  logic [3:0]    oflags;
  logic [$clog2(P+1)-1:0] infl;

  always #5 clk = ~clk;

  fpu_pipe_unit #(.NUM_OP(1), .PIPE_STAGES(P), .TAG_W(TW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .i_alu_op(in_op),
    .i_data_a(a), .i_data_b(b), .i_tag(tag), .i_flush(flush),
    .o_ready(o_ready), .o_valid(o_valid), .i_ready(out_ready),
    .o_result(res), .o_tag(otag), .o_flags(oflags), .o_inflight(infl)
  );

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_flags(input logic [31:0] v);
    logic nan, inf, zero;
    nan  = (v[30:23] == 8'hFF) && (v[22:0] != 0);
    inf  = (v[30:23] == 8'hFF) && (v[22:0] == 0);
    zero = (v[30:0] == 0);
    return {nan, inf, zero, v[31]};
  endfunction

  function automatic logic [31:0] int_to_f(input int v);
    int mag, p;
    logic [31:0] m;
    if (v == 0) return 32'd0;
    mag = (v < 0) ? -v : v;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    m = 32'(mag) << (23 - p);
    return {(v < 0), 8'(127 + p), m[22:0]};
  endfunction

  // scoreboard: every accepted, not-yet-delivered request in order
  typedef struct {logic [31:0] result; logic [TW-1:0] tag;} exp_t;
  exp_t        q[$];
  logic [31:0] exp_cur = '0;
  int          seen = 0, max_infl = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      check("inflight", 32'(infl), 32'(q.size()));
      if (o_valid) begin
        if (q.size() == 0) check("spurious_valid", 32'(o_valid), 32'd0);
        else begin
          check("result", res, q[0].result);
          check("tag", 32'(otag), 32'(q[0].tag));
          check("flags", 32'(oflags), 32'(ref_flags(q[0].result)));
        end
      end
      if (int'(infl) > max_infl) max_infl = int'(infl);
      if (flush) q.delete();
      else begin
        if (o_valid && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          seen++;
        end
        if (in_valid && o_ready) q.push_back('{exp_cur, tag});
      end
    end
  end

  task automatic send(input logic op, input logic [31:0] xa, input logic [31:0] xb,
                      input logic [TW-1:0] t, input logic [31:0] expv);
    bit acc;
    int guard;
    acc = 0;
    guard = 0;
    in_valid = 1'b1; in_op = op; a = xa; b = xb; tag = t; exp_cur = expv;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = o_ready;
      guard++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!o_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!o_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic op; logic [31:0] a, b; logic [TW-1:0] tag; logic [31:0] res; logic [3:0] flags;
  } vec_t;
  vec_t tv[9];

  initial begin
    int lat, s0, g, x, y;
    bit done;
    tv[0] = '{1'b0, 32'h3F80_0000, 32'h4000_0000, 4'd3, 32'h4040_0000, 4'b0000};
    tv[1] = '{1'b1, 32'h4000_0000, 32'h4000_0000, 4'd1, 32'h0000_0000, 4'b0010};
    tv[2] = '{1'b0, 32'h7F80_0000, 32'h3F80_0000, 4'd2, 32'h7F80_0000, 4'b0100};
    tv[3] = '{1'b0, 32'h7FC0_0000, 32'h3F80_0000, 4'd4, 32'h7FC0_0000, 4'b1000};
    tv[4] = '{1'b1, 32'h3F80_0000, 32'h4040_0000, 4'd5, 32'hC000_0000, 4'b0001};
    tv[5] = '{1'b0, 32'h3FC0_0000, 32'h4010_0000, 4'd6, 32'h4070_0000, 4'b0000};
    tv[6] = '{1'b1, 32'hFF80_0000, 32'hFF80_0000, 4'd7, 32'h7FC0_0000, 4'b1000};
    tv[7] = '{1'b0, 32'h3F00_0000, 32'hBE80_0000, 4'd8, 32'h3E80_0000, 4'b0000};
    tv[8] = '{1'b0, 32'h0000_0000, 32'h8000_0000, 4'd9, 32'h0000_0000, 4'b0010};

    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_result", res, 32'd0);
    check("rst_o_tag", 32'(otag), 32'd0);
    check("rst_o_flags", 32'(oflags), 32'd0);
    check("rst_o_inflight", 32'(infl), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(o_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      send(tv[i].op, tv[i].a, tv[i].b, tv[i].tag, tv[i].res);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(P));
      check($sformatf("vec%0d_result", i), res, tv[i].res);
      check($sformatf("vec%0d_flags", i), 32'(oflags), 32'(tv[i].flags));
      check($sformatf("vec%0d_tag", i), 32'(otag), 32'(tv[i].tag));
      @(posedge clk);
      #1;
    end

    // back-to-back stream with a 3-cycle downstream stall after the 2nd result
    s0 = seen;
    max_infl = 0;
    out_ready = 1'b1;
    fork
      for (int i = 0; i < 8; i++) send(1'b0, int_to_f(i), int_to_f(10), 4'(i), int_to_f(i + 10));
      begin
        g = 0;
        while (seen - s0 < 2 && g < 100) begin
          @(posedge clk);
          g++;
        end
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_o_ready", 32'(o_ready), 32'd0);
          check("stall_inflight", 32'(infl), 32'(P));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    g = 0;
    while (seen - s0 < 8 && g < 100) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("stream_count", 32'(seen - s0), 32'd8);
    check("stream_peak_inflight", 32'(max_infl), 32'(P));

    // flush with two requests in flight while downstream is ready
    out_ready = 1'b0;
    send(1'b0, int_to_f(1), int_to_f(1), 4'd8, int_to_f(2));
    send(1'b0, int_to_f(2), int_to_f(2), 4'd9, int_to_f(4));
    out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_o_ready", 32'(o_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_o_valid", 32'(o_valid), 32'd0);
    check("flush_inflight", 32'(infl), 32'd0);
    send(1'b0, int_to_f(1), int_to_f(2), 4'd10, int_to_f(3));
    wait_valid(lat);
    check("post_flush_result", res, 32'h4040_0000);
    check("post_flush_tag", 32'(otag), 32'd10);
    @(posedge clk);
    #1;

    // asynchronous reset with two requests in flight
    out_ready = 1'b0;
    send(1'b0, int_to_f(3), int_to_f(3), 4'd11, int_to_f(6));
    send(1'b0, int_to_f(4), int_to_f(4), 4'd12, int_to_f(8));
    rst_n = 1'b0;
    #1;
    check("arst_o_valid", 32'(o_valid), 32'd0);
    check("arst_o_result", res, 32'd0);
    check("arst_o_tag", 32'(otag), 32'd0);
    check("arst_o_flags", 32'(oflags), 32'd0);
    check("arst_inflight", 32'(infl), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("arst_ready_after", 32'(o_ready), 32'd1);
    send(1'b0, 32'h3F80_0000, 32'h3F80_0000, 4'd13, 32'h4000_0000);
    wait_valid(lat);
    check("arst_next_result", res, 32'h4000_0000);
    @(posedge clk);
    #1;

    // randomized integer-valued operands against the scoreboard
    done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          x = int'($urandom_range(0, 2000)) - 1000;
          y = int'($urandom_range(0, 2000)) - 1000;
          if ($urandom_range(0, 1) == 0)
            send(1'b0, int_to_f(x), int_to_f(y), 4'(i), int_to_f(x + y));
          else
            send(1'b1, int_to_f(x), int_to_f(y), 4'(i), int_to_f(x - y));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    out_ready = 1'b1;
    g = 0;
    while (infl != 0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("random_drain", 32'(infl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
